// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor; signal names keep the block's i_/o_ view.
// SERIAL_SUBTRACTOR_OVF_EN adds the o_ovf result bit.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  // valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its payload steady until that edge.
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_bin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_d;
  logic             o_bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic             o_ovf;

  modport slave (
    input  i_valid, i_a, i_b, i_bin, i_ready,
    output o_ready, o_valid, o_d, o_bout, o_ovf
  );

  modport master (
    output i_valid, i_a, i_b, i_bin, i_ready,
    input  o_ready, o_valid, o_d, o_bout, o_ovf
  );
`else
  modport slave (
    input  i_valid, i_a, i_b, i_bin, i_ready,
    output o_ready, o_valid, o_d, o_bout
  );

  modport master (
    output i_valid, i_a, i_b, i_bin, i_ready,
    input  o_ready, o_valid, o_d, o_bout
  );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: d = a - b - bin, CHUNK bits per cycle, LSB chunk first.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output o_ovf.
module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  serial_subtractor_if.slave   bus,
  output logic [1:0]           o_dbg_state
);

  // WIDTH must be a multiple of CHUNK; the bus WIDTH must match this WIDTH.
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic             borrow_q, bout_q;
  logic [CW-1:0]    cnt_q;

  logic [CHUNK-1:0] a_k, b_k, d_k;
  logic             borrow_k;
  logic             last_chunk;
  logic             accept;
  logic             deliver;

  assign last_chunk = (cnt_q == LAST_CHUNK);
  assign accept     = (state_q == IDLE) && bus.i_valid;
  assign deliver    = (state_q == DONE) && bus.i_ready;

  // Chunk select by constant slices keeps the mux free of variable shifts.
  always_comb begin
    a_k = '0;
    b_k = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CW'(k)) begin
        a_k = a_q[k*CHUNK +: CHUNK];
        b_k = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  assign {borrow_k, d_k} = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK{1'b0}}, borrow_q};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = RUN;
      RUN:     if (last_chunk) state_d = DONE;
      DONE:    if (deliver)    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= bus.i_a;
            b_q      <= bus.i_b;
            borrow_q <= bus.i_bin;
            d_q      <= '0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) d_q[k*CHUNK +: CHUNK] <= d_k;
          end
          borrow_q <= borrow_k;
          if (last_chunk) begin
            bout_q <= borrow_k;
            cnt_q  <= '0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_d     = d_q;
  assign bus.o_bout  = bout_q;
  assign o_dbg_state = state_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // Operands of differing sign overflow when the result sign departs from a.
  assign bus.o_ovf = (state_q == DONE)
                   && (a_q[WIDTH-1] != b_q[WIDTH-1])
                   && (d_q[WIDTH-1] != a_q[WIDTH-1]);
`else
`endif

  a_ready_valid_exclusive: assert property (
    @(posedge i_clk) disable iff (i_rst) !(bus.o_ready && bus.o_valid));

  a_result_held: assert property (
    @(posedge i_clk) disable iff (i_rst)
    (bus.o_valid && !bus.i_ready) |=> (bus.o_valid && $stable(bus.o_d) && $stable(bus.o_bout)));

endmodule
